// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 signed-digit by 8-bit multiplier
//
// Multiplies a two's-complement 8-bit operand by a number given as four
// radix-4 signed digits (each in -2..+2). One digit is processed per clock,
// so a multiply takes four RUN cycles followed by a single DONE cycle.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin a multiply (accepted in IDLE or DONE)
//   y        - two's-complement multiplicand
//   sdn1..4  - signed digits, weights 4^0..4^3; bit[2]=sign, bits[1:0]=magnitude
//   busy     - high while in RUN
//   done     - one-cycle pulse while in DONE
//   product  - 16-bit two's-complement result, held until the next completion

module booth_seq_mult (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  y,
   input  logic [2:0]  sdn1,
   input  logic [2:0]  sdn2,
   input  logic [2:0]  sdn3,
   input  logic [2:0]  sdn4,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [7:0]      y_q;
   logic [3:0][2:0] dig_q;
   logic [15:0]     acc;
   logic [1:0]      cnt;

   logic [2:0]      cur_dig;
   logic [15:0]     y_ext;
   logic [15:0]     pp_mag;
   logic [15:0]     pp_signed;
   logic [15:0]     pp_shift;
   logic [15:0]     sum;

   // Partial product for the digit selected by cnt. Magnitude 3 is not a
   // legal radix-4 digit and is deliberately treated as zero.
   always_comb begin
      cur_dig = dig_q[cnt];
      y_ext   = {{8{y_q[7]}}, y_q};
      case (cur_dig[1:0])
         2'b01:   pp_mag = y_ext;
         2'b10:   pp_mag = {y_ext[14:0], 1'b0};
         default: pp_mag = 16'h0000;
      endcase
      pp_signed = cur_dig[2] ? (16'h0000 - pp_mag) : pp_mag;
      pp_shift  = pp_signed << {cnt, 1'b0};
      sum       = acc + pp_shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= 16'h0000;
         acc     <= 16'h0000;
         cnt     <= 2'd0;
         y_q     <= 8'h00;
         dig_q   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  y_q   <= y;
                  dig_q <= {sdn4, sdn3, sdn2, sdn1};
                  acc   <= 16'h0000;
                  cnt   <= 2'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= sum;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  // Last digit: the result goes straight to product so it is
                  // visible in the same cycle that done is high.
                  product <= sum;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - scoreboard bench for booth_seq_mult

module tb_booth_seq_mult;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  y;
   logic [2:0]  sdn1, sdn2, sdn3, sdn4;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];
   int done_seen = 0;

   booth_seq_mult dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .y       (y),
      .sdn1    (sdn1),
      .sdn2    (sdn2),
      .sdn3    (sdn3),
      .sdn4    (sdn4),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int digit_val(input logic [2:0] d);
      int m;
      case (d[1:0])
         2'b01:   m = 1;
         2'b10:   m = 2;
         default: m = 0;
      endcase
      return d[2] ? -m : m;
   endfunction

   function automatic logic [15:0] model(input logic [7:0] yy, input logic [2:0] d1,
                                         input logic [2:0] d2, input logic [2:0] d3,
                                         input logic [2:0] d4);
      int yv, mv, r;
      yv = int'($signed(yy));
      mv = digit_val(d1) + 4 * digit_val(d2) + 16 * digit_val(d3) + 64 * digit_val(d4);
      r  = yv * mv;
      return r[15:0];
   endfunction

   // Output monitor: exclusivity every cycle, results popped on done.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy_done_excl", {31'd0, busy & done}, 32'd0);
         if (done) begin
            done_seen++;
            if (exp_q.size() == 0)
               check("unexpected_done", 32'd1, 32'd0);
            else
               check("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   // Drive operands and a one-cycle start; returns after edge 0.
   task automatic launch(input logic [7:0] yy, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] d3, input logic [2:0] d4, input bit push);
      @(negedge clk);
      y = yy; sdn1 = d1; sdn2 = d2; sdn3 = d3; sdn4 = d4;
      start = 1'b1;
      if (push) exp_q.push_back(model(yy, d1, d2, d3, d4));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts further rising edges until done is seen at a falling edge.
   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < 12) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (!done) check("done_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_op(input logic [7:0] yy, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] d3, input logic [2:0] d4);
      int e;
      launch(yy, d1, d2, d3, d4, 1'b1);
      check("busy_in_run", {31'd0, busy}, 32'd1);
      wait_done(e);
      // start at edge 0 was already consumed; edges 1..4 remain
      check("latency", e, 32'd4);
   endtask

   initial begin
      int e;
      logic [15:0] held;
      rst_n = 1'b0; start = 1'b0; y = '0;
      sdn1 = '0; sdn2 = '0; sdn3 = '0; sdn4 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 13 * 13 = 169
      run_op(8'd13, 3'b001, 3'b101, 3'b001, 3'b000);
      held = product;
      repeat (3) @(negedge clk);
      check("product_held", {16'd0, product}, {16'd0, held});
      check("idle_busy", {31'd0, busy}, 32'd0);

      // -128 * -128
      run_op(8'h80, 3'b000, 3'b000, 3'b000, 3'b110);

      // 5 * 170 = 850, then back-to-back with start held in DONE
      run_op(8'd5, 3'b010, 3'b010, 3'b010, 3'b010);
      y = 8'hF9; sdn1 = 3'b110; sdn2 = 3'b001; sdn3 = 3'b101; sdn4 = 3'b010;
      start = 1'b1;
      exp_q.push_back(model(8'hF9, 3'b110, 3'b001, 3'b101, 3'b010));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", {31'd0, busy}, 32'd1);
      check("b2b_product_kept", {16'd0, product}, 32'h0352);
      wait_done(e);
      check("b2b_latency", e, 32'd4);

      // start and operand changes during RUN are ignored
      @(negedge clk);
      launch(8'd13, 3'b001, 3'b101, 3'b001, 3'b000, 1'b1);
      start = 1'b1; y = 8'hFF; sdn1 = 3'b110; sdn2 = 3'b110; sdn3 = 3'b110; sdn4 = 3'b110;
      @(negedge clk);
      y = 8'h3C; sdn1 = 3'b010;
      @(negedge clk);
      start = 1'b0;
      wait_done(e);
      check("ignore_product", {16'd0, product}, 32'h00A9);

      // reset during the third RUN cycle
      @(negedge clk);
      launch(8'd77, 3'b010, 3'b010, 3'b010, 3'b010, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_product", {16'd0, product}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      e = done_seen;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_no_done", done_seen, e);
      run_op(8'd77, 3'b010, 3'b010, 3'b010, 3'b010);

      // magnitude 11 contributes zero
      run_op(8'd7, 3'b011, 3'b000, 3'b000, 3'b000);
      run_op(8'd9, 3'b001, 3'b111, 3'b011, 3'b001);

      // random digit patterns
      for (int i = 0; i < 10; i++) begin
         run_op(8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      end

      repeat (2) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
